// File: rtl/conv_mem_responder_pkg.sv
// conv_pkg: shared widths, bank depths, csel encodings and FSM state type for
// the CONV memory responder.
// Ports: none (package).
package conv_pkg;

  localparam int ADDR_BITS = 12;   // 64x64 image
  localparam int DATA_BITS = 20;   // signed 4.16
  localparam int SEL_BITS  = 3;

  localparam int L0_DEPTH  = 4096;
  localparam int L1_DEPTH  = 1024;
  localparam int L2_DEPTH  = 2048;

  localparam int NUM_BANKS = 5;

  localparam logic [SEL_BITS-1:0] SEL_NONE = 3'b000;
  localparam logic [SEL_BITS-1:0] SEL_L0K0 = 3'b001;
  localparam logic [SEL_BITS-1:0] SEL_L0K1 = 3'b010;
  localparam logic [SEL_BITS-1:0] SEL_L1K0 = 3'b011;
  localparam logic [SEL_BITS-1:0] SEL_L1K1 = 3'b100;
  localparam logic [SEL_BITS-1:0] SEL_L2   = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_KICK,
    S_WAIT_HI,
    S_RUN,
    S_DONE
  } state_t;

  // Bank index 0..4 maps to csel 001..101 in order.
  function automatic logic [SEL_BITS-1:0] bank_sel(input int idx);
    return SEL_BITS'(idx + 1);
  endfunction

  function automatic int bank_depth(input int idx);
    case (idx)
      0, 1:    return L0_DEPTH;
      2, 3:    return L1_DEPTH;
      default: return L2_DEPTH;
    endcase
  endfunction

endpackage

// File: rtl/conv_mem_responder_bank.sv
// conv_bank: single-write-port, asynchronous-read array with address range
// check. Out-of-range writes are dropped and out-of-range reads return 0.
// Ports:
//   clk                  write clock
//   we/waddr/wdata       write port (commits on posedge clk when in range)
//   raddr/rdata          combinational read port
//   waddr_ok/raddr_ok    address < DEPTH
module conv_bank
  import conv_pkg::*;
#(
  parameter int DEPTH = L1_DEPTH,
  parameter int AW    = ADDR_BITS,
  parameter int DW    = DATA_BITS
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  output logic          waddr_ok,
  output logic          raddr_ok
);

  localparam int            IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   LIMIT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  // One extra bit so a full 2^AW-deep bank still compares correctly.
  assign waddr_ok = {1'b0, waddr} < LIMIT;
  assign raddr_ok = {1'b0, raddr} < LIMIT;

  assign rdata = raddr_ok ? mem[raddr[IW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (we && waddr_ok) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/conv_mem_responder.sv
// conv_mem_responder: memory-side responder for the CONV engine. Holds the
// image buffer and the five layer banks, runs the start/load/kick/run/done
// sequence and offers the host a registered readback port in IDLE.
// Optional: define MEM_CLEAR_EN to zero all five banks (one address per cycle,
// all banks in parallel) between start and LOAD.
// Ports:
//   clk, reset            clock, async active-high reset
//   start, load_done      host sequencing pulses
//   host_wr/addr/data     image load port (LOAD only)
//   ready, busy           kick-off handshake with the engine
//   iaddr -> idata        combinational image read
//   cwr/caddr_wr/cdata_wr engine layer write; crd/caddr_rd -> cdata_rd read
//   csel                  bank select for engine accesses
//   host_rd_*             readback request/response (IDLE only)
//   done                  one-cycle completion pulse
//   err_sel, err_addr     sticky error flags (cleared on start)
//   wr_count              accepted engine writes this run (saturating)
module conv_mem_responder
  import conv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 host_wr,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [DATA_BITS-1:0] host_data,
  input  logic                 load_done,
  output logic                 ready,
  input  logic                 busy,
  input  logic [ADDR_BITS-1:0] iaddr,
  output logic [DATA_BITS-1:0] idata,
  input  logic                 cwr,
  input  logic [ADDR_BITS-1:0] caddr_wr,
  input  logic [DATA_BITS-1:0] cdata_wr,
  input  logic                 crd,
  input  logic [ADDR_BITS-1:0] caddr_rd,
  output logic [DATA_BITS-1:0] cdata_rd,
  input  logic [SEL_BITS-1:0]  csel,
  input  logic                 host_rd_en,
  input  logic [SEL_BITS-1:0]  host_rd_sel,
  input  logic [ADDR_BITS-1:0] host_rd_addr,
  output logic [DATA_BITS-1:0] host_rd_data,
  output logic                 host_rd_valid,
  output logic                 done,
  output logic                 err_sel,
  output logic                 err_addr,
  output logic [15:0]          wr_count
);

  state_t state, state_nx;
  logic   idle, run;

  assign idle = (state == S_IDLE);
  assign run  = (state == S_RUN);

  // ---------------- optional bank clear ----------------
  logic                 clr_active;
  logic                 clr_last;
  logic [ADDR_BITS-1:0] clr_cnt;

`ifdef MEM_CLEAR_EN
  localparam state_t START_STATE = S_CLEAR;

  assign clr_active = (state == S_CLEAR);
  assign clr_last   = (clr_cnt == '0);

  // Sweeps L0_DEPTH-1 down to 0; shallower banks drop the high addresses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt <= '0;
    end else if (idle && start) begin
      clr_cnt <= ADDR_BITS'(L0_DEPTH - 1);
    end else if (clr_active) begin
      clr_cnt <= clr_cnt - 1'b1;
    end
  end
`else
  localparam state_t START_STATE = S_LOAD;

  assign clr_active = 1'b0;
  assign clr_last   = 1'b1;
  assign clr_cnt    = '0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nx = START_STATE;
      S_CLEAR:   if (clr_last) state_nx = S_LOAD;
      S_LOAD:    if (load_done) state_nx = S_KICK;
      S_KICK: begin
        ready    = 1'b1;
        state_nx = S_WAIT_HI;
      end
      S_WAIT_HI: if (busy) state_nx = S_RUN;
      S_RUN:     if (!busy) state_nx = S_DONE;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default:   state_nx = S_IDLE;
    endcase
  end

  // ---------------- image buffer ----------------
  logic [DATA_BITS-1:0] img_rdata;
  logic                 img_wok, img_rok;
  logic                 img_we;

  assign img_we = (state == S_LOAD) && host_wr && img_wok;
  assign idata  = img_rok ? img_rdata : '0;

  conv_bank #(.DEPTH(L0_DEPTH)) u_image (
    .clk      (clk),
    .we       (img_we),
    .waddr    (host_addr),
    .wdata    (host_data),
    .raddr    (iaddr),
    .rdata    (img_rdata),
    .waddr_ok (img_wok),
    .raddr_ok (img_rok)
  );

  // ---------------- layer banks ----------------
  logic [NUM_BANKS-1:0] b_we, b_wok, b_rok;
  logic [ADDR_BITS-1:0] b_waddr, b_raddr;
  logic [DATA_BITS-1:0] b_wdata;
  logic [DATA_BITS-1:0] b_rdata [NUM_BANKS];

  assign b_waddr = clr_active ? clr_cnt : caddr_wr;
  assign b_wdata = clr_active ? '0 : cdata_wr;
  // Readback only happens in IDLE and engine reads only in RUN, so one
  // read port per bank is shared.
  assign b_raddr = idle ? host_rd_addr : caddr_rd;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign b_we[gi] = clr_active || (run && cwr && (csel == bank_sel(gi)));

    conv_bank #(.DEPTH(bank_depth(gi))) u_bank (
      .clk      (clk),
      .we       (b_we[gi]),
      .waddr    (b_waddr),
      .wdata    (b_wdata),
      .raddr    (b_raddr),
      .rdata    (b_rdata[gi]),
      .waddr_ok (b_wok[gi]),
      .raddr_ok (b_rok[gi])
    );
  end

  logic                 sel_legal, sel_wok, sel_rok;
  logic [DATA_BITS-1:0] sel_rdata, hr_rdata;

  always_comb begin
    sel_legal = 1'b0;
    sel_wok   = 1'b0;
    sel_rok   = 1'b0;
    sel_rdata = '0;
    hr_rdata  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (csel == bank_sel(i)) begin
        sel_legal = 1'b1;
        sel_wok   = b_wok[i];
        sel_rok   = b_rok[i];
        sel_rdata = b_rdata[i];
      end
      if (host_rd_sel == bank_sel(i)) begin
        hr_rdata = b_rdata[i];
      end
    end
  end

  assign cdata_rd = (run && crd && sel_legal) ? sel_rdata : '0;

  // ---------------- status / readback ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sel       <= 1'b0;
      err_addr      <= 1'b0;
      wr_count      <= '0;
      host_rd_valid <= 1'b0;
      host_rd_data  <= '0;
    end else begin
      host_rd_valid <= idle && host_rd_en;
      host_rd_data  <= (idle && host_rd_en) ? hr_rdata : '0;
      if (idle && start) begin
        err_sel  <= 1'b0;
        err_addr <= 1'b0;
        wr_count <= '0;
      end else if (run) begin
        if ((cwr || crd) && !sel_legal) begin
          err_sel <= 1'b1;
        end
        if (sel_legal && ((cwr && !sel_wok) || (crd && !sel_rok))) begin
          err_addr <= 1'b1;
        end
        if (cwr && sel_legal && sel_wok && (wr_count != 16'hFFFF)) begin
          wr_count <= wr_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_mem_responder.sv
module tb_conv_mem_responder;
  import conv_pkg::*;

  logic                 clk = 1'b0, reset = 1'b0;
  logic                 start = 1'b0, host_wr = 1'b0, load_done = 1'b0, busy = 1'b0;
  logic                 cwr = 1'b0, crd = 1'b0, host_rd_en = 1'b0;
  logic [ADDR_BITS-1:0] host_addr = '0, iaddr = '0, caddr_wr = '0, caddr_rd = '0, host_rd_addr = '0;
  logic [DATA_BITS-1:0] host_data = '0, cdata_wr = '0;
  logic [SEL_BITS-1:0]  csel = '0, host_rd_sel = '0;
  logic                 ready, done, host_rd_valid, err_sel, err_addr;
  logic [DATA_BITS-1:0] idata, cdata_rd, host_rd_data;
  logic [15:0]          wr_count;

  conv_mem_responder dut (
    .clk(clk), .reset(reset), .start(start), .host_wr(host_wr), .host_addr(host_addr),
    .host_data(host_data), .load_done(load_done), .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .host_rd_en(host_rd_en), .host_rd_sel(host_rd_sel), .host_rd_addr(host_rd_addr),
    .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid), .done(done),
    .err_sel(err_sel), .err_addr(err_addr), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // reference model
  logic [DATA_BITS-1:0] mdl [int];   // key = sel*4096 + addr
  logic [DATA_BITS-1:0] img [int];
  int                   touched[$];
  bit                   cleared = 0;
  int                   exp_wr_count = 0;
  bit                   exp_err_sel = 0, exp_err_addr = 0;
  int                   bad_sel [3] = '{0, 6, 7};
  int                   last_load_addr;

  logic [DATA_BITS-1:0] rb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int depth_of(input int sel);
    case (sel)
      1, 2:    return 4096;
      3, 4:    return 1024;
      5:       return 2048;
      default: return 0;
    endcase
  endfunction

  function automatic bit mdl_known(input int sel, input int addr);
    if (depth_of(sel) == 0 || addr >= depth_of(sel)) return 1'b1;
    return cleared || mdl.exists(sel * 4096 + addr);
  endfunction

  function automatic logic [DATA_BITS-1:0] mdl_read(input int sel, input int addr);
    if (depth_of(sel) == 0 || addr >= depth_of(sel)) return '0;
    if (mdl.exists(sel * 4096 + addr)) return mdl[sel * 4096 + addr];
    return '0;
  endfunction

  function automatic int pick_addr(input int dp);
    int lim;
    lim = (dp == 0) ? 1024 : dp;
    case ($urandom_range(0, 7))
      0:       return (lim >= 4096) ? 4095 : lim;
      1:       return lim - 1;
      default: return int'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every valid readback must match the oldest expectation.
  always @(negedge clk) begin
    logic [DATA_BITS-1:0] e;
    if (!reset && host_rd_valid) begin
      if (rb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rb_unexpected: valid=1 data=%h, expected no response", host_rd_data);
      end else begin
        e = rb_q.pop_front();
        check("readback", host_rd_data, e);
      end
    end
  end

  task automatic rb(input int sel, input int addr);
    host_rd_en   = 1'b1;
    host_rd_sel  = SEL_BITS'(sel);
    host_rd_addr = ADDR_BITS'(addr);
    rb_q.push_back(mdl_read(sel, addr));
    tick();
    host_rd_en = 1'b0;
  endtask

  task automatic rb_touched();
    for (int i = 0; i < touched.size() && i < 40; i++) begin
      if (mdl_known(touched[i] / 4096, touched[i] % 4096))
        rb(touched[i] / 4096, touched[i] % 4096);
    end
    repeat (2) tick();
  endtask

  task automatic eng(input bit w, input bit r, input int sel, input int wa, input int ra,
                     input logic [DATA_BITS-1:0] wd, input bit hre);
    int dp;
    dp           = depth_of(sel);
    cwr          = w;
    crd          = r;
    csel         = SEL_BITS'(sel);
    caddr_wr     = ADDR_BITS'(wa);
    caddr_rd     = ADDR_BITS'(ra);
    cdata_wr     = wd;
    host_rd_en   = hre;
    host_rd_sel  = SEL_BITS'($urandom_range(0, 7));
    host_rd_addr = ADDR_BITS'($urandom_range(0, 15));
    @(negedge clk);
    if (!r) check("cdata_rd_no_crd", cdata_rd, '0);
    else if (mdl_known(sel, ra)) check("cdata_rd", cdata_rd, mdl_read(sel, ra));
    if (w || r) begin
      if (dp == 0) exp_err_sel = 1'b1;
      else if ((w && wa >= dp) || (r && ra >= dp)) exp_err_addr = 1'b1;
    end
    if (w && dp != 0 && wa < dp) begin
      mdl[sel * 4096 + wa] = wd;
      touched.push_back(sel * 4096 + wa);
      if (exp_wr_count < 65535) exp_wr_count++;
    end
    tick();
    cwr = 1'b0; crd = 1'b0; host_rd_en = 1'b0;
    check("err_sel", err_sel, exp_err_sel);
    check("err_addr", err_addr, exp_err_addr);
    check("wr_count", wr_count, exp_wr_count);
  endtask

  task automatic chk_idata(input int a);
    iaddr = ADDR_BITS'(a);
    @(negedge clk);
    check("idata", idata, img[a]);
    tick();
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_err_sel = 0; exp_err_addr = 0; exp_wr_count = 0;
    check("start_clr_err_sel", err_sel, 0);
    check("start_clr_err_addr", err_addr, 0);
    check("start_clr_wr_count", wr_count, 0);
`ifdef MEM_CLEAR_EN
    mdl.delete();
    cleared = 1;
    repeat (L0_DEPTH) tick();
`endif
  endtask

  task automatic load_and_kick(input bit abort_in_kick);
    int a;
    host_wr = 1'b1; host_addr = '0; host_data = 20'h00010; img[0] = 20'h00010;
    tick();
    host_addr = 12'd4095; host_data = 20'hFFFF0; img[4095] = 20'hFFFF0;
    tick();
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(1, 4094));
      host_addr = ADDR_BITS'(a); host_data = DATA_BITS'($urandom); img[a] = host_data;
      tick();
    end
    last_load_addr = int'($urandom_range(1, 4094));
    host_addr = ADDR_BITS'(last_load_addr); host_data = DATA_BITS'($urandom);
    img[last_load_addr] = host_data;
    load_done = 1'b1;
    @(negedge clk);
    check("ready_in_load", ready, 0);
    tick();
    host_wr = 1'b0; load_done = 1'b0;
    @(negedge clk);
    check("ready_kick", ready, 1);
    if (abort_in_kick) begin
      #2 reset = 1'b1; busy = 1'b0;
      #1;
      check("ready_async_reset", ready, 0);
      check("done_async_reset", done, 0);
      exp_err_sel = 0; exp_err_addr = 0; exp_wr_count = 0;
      @(negedge clk);
      reset = 1'b0;
      tick();
    end else begin
      tick();
      busy = 1'b1;
      @(negedge clk);
      check("ready_one_cycle", ready, 0);
      tick();
    end
  endtask

  task automatic finish_run();
    busy = 1'b0;
    @(negedge clk);
    check("done_before", done, 0);
    tick();
    @(negedge clk);
    check("done_pulse", done, 1);
    tick();
    @(negedge clk);
    check("done_after", done, 0);
    tick();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1; busy = 1'b0; cwr = 1'b0; crd = 1'b0; host_rd_en = 1'b0;
    #1;
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_err_sel", err_sel, 0);
    exp_err_sel = 0; exp_err_addr = 0; exp_wr_count = 0;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, wa, ra;
    #1 reset = 1'b1;
    #2;
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    check("rst_valid", host_rd_valid, 0);
    check("rst_rd_data", host_rd_data, 0);
    check("rst_err_sel", err_sel, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_wr_count", wr_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick();

    // illegal readbacks return 0 and raise no flag
    rb(6, 0); rb(3, 1024); rb(0, 5); rb(5, 2048);
    repeat (2) tick();
    check("rb_no_err_sel", err_sel, 0);
    check("rb_no_err_addr", err_addr, 0);

    // ---- run 1 ----
    start_run();
    load_and_kick(1'b0);
    chk_idata(0);
    chk_idata(4095);
    chk_idata(last_load_addr);
    eng(1, 0, 4, 5, 0, 20'h54321, 0);
    eng(1, 0, 3, 5, 0, 20'h12345, 0);
    eng(0, 1, 3, 0, 5, '0, 0);
    eng(0, 1, 4, 0, 5, '0, 0);
    eng(1, 0, 5, 2047, 0, 20'h0ABCD, 0);
    eng(1, 0, 6, 7, 0, 20'h11111, 0);
    eng(1, 0, 3, 1024, 0, 20'h22222, 0);
    eng(0, 1, 3, 0, 1024, '0, 0);
    eng(1, 1, 3, 5, 5, 20'h33333, 0);
    eng(0, 1, 3, 0, 5, '0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_run_ignored", err_sel, 1);
    for (int i = 0; i < 150; i++) begin
      sel = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 5)) : bad_sel[$urandom_range(0, 2)];
      wa  = pick_addr(depth_of(sel));
      ra  = ($urandom_range(0, 1) == 1) ? wa : pick_addr(depth_of(sel));
      eng(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sel, wa, ra,
          DATA_BITS'($urandom), ($urandom_range(0, 15) == 0));
    end
    finish_run();
    rb(5, 2047); rb(3, 5); rb(4, 5);
    rb_touched();

    // ---- run 2: reset while in RUN ----
    start_run();
    load_and_kick(1'b0);
    for (int i = 0; i < 20; i++) begin
      sel = int'($urandom_range(1, 5));
      eng(1, 0, sel, int'($urandom_range(16, 31)), 0, DATA_BITS'($urandom), 0);
    end
    do_reset();
    rb_touched();

    // ---- run 3: reset while ready is high ----
    start_run();
    load_and_kick(1'b1);
    rb(5, 2047);
    rb_touched();

    repeat (3) tick();
    check("rb_queue_drained", rb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
